// File: rtl/lcd_timing_gen_if.sv
// Panel-side signal bundle for lcd_timing_gen: pixel strobe in, raster timing and coordinates out.
interface lcd_timing_gen_if #(
    parameter int w_x     = 10,
    parameter int w_y     = 9,
    parameter int w_frame = 8
);
    logic               pix_en;
    logic               de;
    logic               hsync;
    logic               vsync;
    logic [w_x-1:0]     x;
    logic [w_y-1:0]     y;
    logic               frame_start;
    logic [w_frame-1:0] frame_count;

    modport master (
        input  pix_en,
        output de, hsync, vsync, x, y, frame_start, frame_count
    );

    modport slave (
        output pix_en,
        input  de, hsync, vsync, x, y, frame_start, frame_count
    );
endinterface

// File: rtl/lcd_timing_gen.sv
// Parametrised raster timing generator (active, front porch, sync, back porch on both axes).
// Optional macro LCD_TIMING_MIRROR_EN reverses x/y for panels mounted rotated 180 degrees.
module lcd_timing_gen #(
    parameter int screen_width  = 800,
    parameter int screen_height = 480,
    parameter int h_front       = 210,
    parameter int h_sync        = 20,
    parameter int h_back        = 26,
    parameter int v_front       = 22,
    parameter int v_sync        = 10,
    parameter int v_back        = 13,
    parameter int hs_active_low = 1,
    parameter int vs_active_low = 1,
    parameter int w_frame       = 8,
    parameter int w_x           = $clog2(screen_width),
    parameter int w_y           = $clog2(screen_height)
) (
    input  logic             clk,
    input  logic             rst,
    lcd_timing_gen_if.master bus
);

    localparam int h_total = screen_width + h_front + h_sync + h_back;
    localparam int v_total = screen_height + v_front + v_sync + v_back;
    localparam int w_hc    = $clog2(h_total);
    localparam int w_vc    = $clog2(v_total);

    localparam logic [w_hc-1:0] h_last       = w_hc'(h_total - 1);
    localparam logic [w_vc-1:0] v_last       = w_vc'(v_total - 1);
    localparam logic [w_hc-1:0] h_act_end    = w_hc'(screen_width);
    localparam logic [w_vc-1:0] v_act_end    = w_vc'(screen_height);
    localparam logic [w_hc-1:0] h_sync_start = w_hc'(screen_width + h_front);
    localparam logic [w_hc-1:0] h_sync_end   = w_hc'(screen_width + h_front + h_sync);
    localparam logic [w_vc-1:0] v_sync_start = w_vc'(screen_height + v_front);
    localparam logic [w_vc-1:0] v_sync_end   = w_vc'(screen_height + v_front + v_sync);
    localparam logic [w_x-1:0]  x_last       = w_x'(screen_width - 1);
    localparam logic [w_y-1:0]  y_last       = w_y'(screen_height - 1);
    localparam logic            hs_on        = (hs_active_low == 0);
    localparam logic            vs_on        = (vs_active_low == 0);

    if (h_front < 1 || h_sync < 1 || h_back < 1 ||
        v_front < 1 || v_sync < 1 || v_back < 1) begin : g_bad_porch
        $fatal(1, "lcd_timing_gen: every porch and sync width must be at least 1");
    end
    if (screen_width > (2 ** w_x)) begin : g_bad_w_x
        $fatal(1, "lcd_timing_gen: w_x too narrow for screen_width");
    end
    if (screen_height > (2 ** w_y)) begin : g_bad_w_y
        $fatal(1, "lcd_timing_gen: w_y too narrow for screen_height");
    end

    logic [w_hc-1:0]    hc_reg, hc_next;
    logic [w_vc-1:0]    vc_reg, vc_next;
    logic [w_frame-1:0] frame_count_reg, frame_count_next;
    logic               de_reg, de_next;
    logic               hsync_reg, hsync_next;
    logic               vsync_reg, vsync_next;
    logic [w_x-1:0]     x_reg, x_next;
    logic [w_y-1:0]     y_reg, y_next;
    logic               frame_start_reg, frame_start_next;

    // Outputs are the decode of the counters as they stand before the strobe.
    always_comb begin
        hc_next          = hc_reg + 1'b1;
        vc_next          = vc_reg;
        frame_count_next = frame_count_reg;
        if (hc_reg == h_last) begin
            hc_next = '0;
            vc_next = vc_reg + 1'b1;
            if (vc_reg == v_last) begin
                vc_next          = '0;
                frame_count_next = frame_count_reg + 1'b1;
            end
        end

        de_next          = (hc_reg < h_act_end) && (vc_reg < v_act_end);
        hsync_next       = ((hc_reg >= h_sync_start) && (hc_reg < h_sync_end)) ? hs_on : ~hs_on;
        vsync_next       = ((vc_reg >= v_sync_start) && (vc_reg < v_sync_end)) ? vs_on : ~vs_on;
        frame_start_next = (hc_reg == '0) && (vc_reg == '0);

        x_next = '0;
        y_next = '0;
        if (de_next) begin
`ifdef LCD_TIMING_MIRROR_EN
            x_next = x_last - w_x'(hc_reg);
            y_next = y_last - w_y'(vc_reg);
`else
            x_next = w_x'(hc_reg);
            y_next = w_y'(vc_reg);
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hc_reg          <= '0;
            vc_reg          <= '0;
            frame_count_reg <= '0;
            de_reg          <= 1'b0;
            hsync_reg       <= ~hs_on;
            vsync_reg       <= ~vs_on;
            x_reg           <= '0;
            y_reg           <= '0;
            frame_start_reg <= 1'b0;
        end else begin
            // frame_start is a single-clock pulse even when strobes are sparse.
            frame_start_reg <= 1'b0;
            if (bus.pix_en) begin
                hc_reg          <= hc_next;
                vc_reg          <= vc_next;
                frame_count_reg <= frame_count_next;
                de_reg          <= de_next;
                hsync_reg       <= hsync_next;
                vsync_reg       <= vsync_next;
                x_reg           <= x_next;
                y_reg           <= y_next;
                frame_start_reg <= frame_start_next;
            end
        end
    end

    assign bus.de          = de_reg;
    assign bus.hsync       = hsync_reg;
    assign bus.vsync       = vsync_reg;
    assign bus.x           = x_reg;
    assign bus.y           = y_reg;
    assign bus.frame_start = frame_start_reg;
    assign bus.frame_count = frame_count_reg;

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Directed bench for lcd_timing_gen on a 4x2 raster (h_total=8, v_total=5) with active-low syncs.
module tb_lcd_timing_gen;

    localparam int W  = 4;
    localparam int H  = 2;
    localparam int WX = $clog2(W);
    localparam int WY = $clog2(H);

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pix_en = 1'b0;

    always #5 clk = ~clk;

    lcd_timing_gen_if #(.w_x(WX), .w_y(WY), .w_frame(8)) bus ();
    lcd_timing_gen_if #(.w_x(WX), .w_y(WY), .w_frame(2)) bus2 ();

    assign bus.pix_en  = pix_en;
    assign bus2.pix_en = pix_en;

    lcd_timing_gen #(
        .screen_width(W), .screen_height(H),
        .h_front(1), .h_sync(2), .h_back(1),
        .v_front(1), .v_sync(1), .v_back(1),
        .hs_active_low(1), .vs_active_low(1),
        .w_frame(8), .w_x(WX), .w_y(WY)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    lcd_timing_gen #(
        .screen_width(W), .screen_height(H),
        .h_front(1), .h_sync(2), .h_back(1),
        .v_front(1), .v_sync(1), .v_back(1),
        .hs_active_low(1), .vs_active_low(1),
        .w_frame(2), .w_x(WX), .w_y(WY)
    ) dut_fc2 (
        .clk(clk),
        .rst(rst),
        .bus(bus2)
    );

    // Hand-derived per-column and per-row expectations for the 4x2 raster.
    int col_de[8]   = '{1, 1, 1, 1, 0, 0, 0, 0};
    int col_hs[8]   = '{1, 1, 1, 1, 1, 0, 0, 1};
    int row_act[5]  = '{1, 1, 0, 0, 0};
    int row_vs[5]   = '{1, 1, 1, 0, 1};
`ifdef LCD_TIMING_MIRROR_EN
    int col_x[8]    = '{3, 2, 1, 0, 0, 0, 0, 0};
    int row_y[5]    = '{1, 0, 0, 0, 0};
`else
    int col_x[8]    = '{0, 1, 2, 3, 0, 0, 0, 0};
    int row_y[5]    = '{0, 1, 0, 0, 0};
`endif

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic strobe();
        pix_en = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        pix_en = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string ph);
        check({ph, " de"},    32'(bus.de), 0);
        check({ph, " hsync"}, 32'(bus.hsync), 1);
        check({ph, " vsync"}, 32'(bus.vsync), 1);
        check({ph, " x"},     32'(bus.x), 0);
        check({ph, " y"},     32'(bus.y), 0);
        check({ph, " fs"},    32'(bus.frame_start), 0);
        check({ph, " fc"},    32'(bus.frame_count), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        pix_en = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // s is the strobe index within the frame; fs_exp lets hold-cycle checks demand frame_start=0.
    task automatic check_strobe(input string ph, input int s, input int fs_exp);
        int p, r, c, de_e;
        p = s % 40;
        r = p / 8;
        c = p % 8;
        de_e = col_de[c] & row_act[r];
        check($sformatf("%s s%0d de", ph, s),    32'(bus.de), 32'(de_e));
        check($sformatf("%s s%0d x", ph, s),     32'(bus.x), 32'(de_e ? col_x[c] : 0));
        check($sformatf("%s s%0d y", ph, s),     32'(bus.y), 32'(de_e ? row_y[r] : 0));
        check($sformatf("%s s%0d hsync", ph, s), 32'(bus.hsync), 32'(col_hs[c]));
        check($sformatf("%s s%0d vsync", ph, s), 32'(bus.vsync), 32'(row_vs[r]));
        check($sformatf("%s s%0d fs", ph, s),    32'(bus.frame_start), 32'(fs_exp));
    endtask

    initial begin
        rst = 1'b1;
        pix_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("reset");
        rst = 1'b0;

        // Full frame plus one strobe: line/frame wrap and frame_count increment on strobe 39.
        for (int s = 0; s <= 40; s++) begin
            strobe();
            check_strobe("run", s, (s % 40 == 0) ? 1 : 0);
            check($sformatf("run s%0d fc", s), 32'(bus.frame_count), (s >= 39) ? 1 : 0);
        end

        // Advance to hc=5, vc=1 of the second frame, then reset with pix_en low.
        for (int s = 41; s <= 52; s++) strobe();
        check("pre-rst fc", 32'(bus.frame_count), 1);
        rst = 1'b1;
        pix_en = 1'b0;
        @(posedge clk);
        #1;
        check_reset_state("midrst");
        rst = 1'b0;
        for (int s = 0; s < 8; s++) begin
            strobe();
            check_strobe("after_rst", s, (s == 0) ? 1 : 0);
        end

        // Sparse strobes: pattern 1,0,0 repeating; outputs hold, frame_start lasts one clock.
        do_reset();
        for (int s = 0; s < 8; s++) begin
            strobe();
            check_strobe("sparse", s, (s == 0) ? 1 : 0);
            idle();
            check_strobe("hold1", s, 0);
            idle();
            check_strobe("hold2", s, 0);
        end

        // Narrow frame counter wraps 0,1,2,3,0.
        do_reset();
        for (int s = 0; s < 160; s++) begin
            strobe();
            if (s == 0)
                check("fc2 s0", 32'(bus2.frame_count), 0);
            if (s % 40 == 39)
                check($sformatf("fc2 s%0d", s), 32'(bus2.frame_count), 32'(((s / 40) + 1) % 4));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
